seq_control_unit: RTL
=====================

// Module: seq_control_unit
// PURPOSE
//  ID-stage control unit with a registered macro-op sequencer. Decodes single-cycle ops
//  combinationally, as the current control unit does. Expands SWAP into SWAP_STEPS
//  micro-ops with a proper FSM. Holds IF/ID with freeze until the last step, and obeys
//  hazard-stall and branch-flush. Drop-in successor feeding the ID/EXE pipeline register.
// PARAMETERS
//  OPC_W          6        opcode width
//  CMD_W          4        exec_cmd width
//  SWAP_OPC       6'h3F    opcode expanded by the sequencer
//  SWAP_STEPS     2        micro-ops per SWAP, legal 2..7
//  SWAP_CMD_BASE  4'b1100  exec_cmd of step 0; step k issues SWAP_CMD_BASE+k
//  SEL_W          3        swp_sel width; must satisfy 2^SEL_W > SWAP_STEPS
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  opcode       in   OPC_W  opcode of instruction in ID
//  hazard_stall in   1      hazard unit inserting bubble this cycle
//  flush        in   1      branch taken in EXE; kill ID instruction
//  freeze       out  1      hold PC and IF/ID this cycle
//  swp_sel      out  SEL_W  0 = normal operand path, k+1 = SWAP step k
//  exec_cmd     out  CMD_W  ALU command
//  mem_r_en, mem_w_en, wb_en, is_imm, single_src   out 1  stage controls
//  branch_type  out  2      00 none, 01 BEZ, 10 BNE, 11 JMP
//  illegal_op   out  1      sticky undefined-opcode flag (macro only)
// BEHAVIOUR
//  - Reset: state IDLE, step 0, illegal_op 0. While rst=1 every output is 0.
//  - Single-cycle ops: 0-cycle combinational decode. The encodings are unchanged:
//    NOP 000000, ADD 000001, SUB 000011, AND 000101, OR 000110, NOR 000111, XOR 001000,
//    SLA/SLL 001001/001010, SRA 001011, SRL 001100, ADDI 100000, SUBI 100001,
//    LD 100100, ST 100101, BEZ 101000, BNE 101001, JMP 101010.
//  - FSM states: IDLE, SEQ(step k).
//    - IDLE with opcode==SWAP_OPC: step 0 is driven combinationally this cycle; the next edge goes to SEQ(1).
//    - SEQ(k) -> SEQ(k+1) on each edge; the last step returns to IDLE.
//  - Each SWAP step drives: exec_cmd=SWAP_CMD_BASE+k, swp_sel=k+1, wb_en=1, all other controls 0.
//  - freeze=1 on every SWAP step except the last, so the instruction after SWAP enters ID on
//    the edge that ends the last step. Total SWAP occupancy is exactly SWAP_STEPS cycles.
//  - opcode is ignored while in SEQ; the IF/ID register is frozen, so it is stable anyway.
//  - hazard_stall=1: all controls and freeze are driven to 0 (bubble); the FSM state holds.
//  - flush=1: all controls are 0, freeze=0, FSM returns to IDLE on the next edge. flush has priority over hazard_stall.
//  - rst asserted mid-sequence: outputs go to 0 immediately; IDLE after release.
//  - Undefined opcode: decoded as NOP.
//  - Back-to-back SWAP: IDLE is re-entered for one cycle and the new SWAP starts there; no bubble.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode in IDLE, with no stall and no flush, sets
//    illegal_op=1 on the next edge. It stays set until rst. The instruction still executes as NOP.
//  CTRL_ILLEGAL_TRAP_EN undefined: illegal_op tied 0, no flop is inferred.
// STRUCTURE
//  - Package ctrl_pkg.vh holds the opcode localparams, the exec_cmd encodings, the
//    branch_type encodings and the FSM state encoding.
//  - Sub-module ctrl_decode is purely combinational: opcode -> single-cycle control word.
//  - seq_control_unit holds the FSM, step counter, output mux and stall/flush masking.
// TESTING
//  1. opcode=000001 (ADD) -> exec_cmd=0000, wb_en=1, freeze=0, swp_sel=0, same cycle.
//  2. opcode=6'h3F, SWAP_STEPS=2, cycles 0 and 1:
//     - cycle 0: exec_cmd=1100, swp_sel=1, freeze=1
//     - cycle 1: exec_cmd=1101, swp_sel=2, freeze=0
//     - cycle 2: IDLE.
//  3. SWAP with hazard_stall=1 in cycle 1 -> cycle 1 all zero; cycle 2 repeats step 1 (1101, swp_sel=2).
//  4. flush=1 during step 0 -> outputs 0, next cycle IDLE decoding the new opcode. rst mid-SWAP -> outputs 0 at once.
//  5. Two consecutive SWAPs -> 1100,1101,1100,1101 with freeze=1,0,1,0.
//  6. opcode=6'b010101 -> NOP controls; illegal_op=1 next cycle and held with macro, stays 0 without.

Source files
------------

// File: rtl/seq_control_unit_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, ALU commands,
// branch types, sequencer state and the single-cycle control word.
package seq_control_unit_pkg;

    localparam int OPC_WIDTH = 6;
    localparam int CMD_WIDTH = 4;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    // Shift-left arithmetic and logical are the same ALU operation.
    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SHL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;

    localparam logic [1:0] BR_BEZ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    // single_src: instruction does not read the second source register.
    typedef struct packed {
        logic [CMD_WIDTH-1:0] exec_cmd;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 wb_en;
        logic                 is_imm;
        logic                 single_src;
        logic [1:0]           branch_type;
    } ctrl_word_t;

endpackage

// File: rtl/seq_control_unit_if.sv
// Handshake bundle between the ID stage (master) and the control unit (slave).
interface seq_control_unit_if #(
    parameter int OPC_W = 6,
    parameter int CMD_W = 4,
    parameter int SEL_W = 3
);
    logic [OPC_W-1:0] opcode;
    logic             hazard_stall;
    logic             flush;
    logic             freeze;
    logic [SEL_W-1:0] swp_sel;
    logic [CMD_W-1:0] exec_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             is_imm;
    logic             single_src;
    logic [1:0]       branch_type;
    logic             illegal_op;

    modport master (
        output opcode, hazard_stall, flush,
        input  freeze, swp_sel, exec_cmd, mem_r_en, mem_w_en, wb_en,
               is_imm, single_src, branch_type, illegal_op
    );

    modport slave (
        input  opcode, hazard_stall, flush,
        output freeze, swp_sel, exec_cmd, mem_r_en, mem_w_en, wb_en,
               is_imm, single_src, branch_type, illegal_op
    );
endinterface

// File: rtl/seq_control_unit_decode.sv
// Purely combinational single-cycle decoder: opcode -> control word.
// valid=0 flags an opcode outside the single-cycle set (decoded as NOP).
module seq_control_unit_decode
    import seq_control_unit_pkg::*;
(
    input  logic [OPC_WIDTH-1:0] opcode,
    output ctrl_word_t           word,
    output logic                 valid
);
    always_comb begin
        word  = '0;
        valid = 1'b1;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin word.exec_cmd = CMD_ADD; word.wb_en = 1'b1; end
            OP_SUB:  begin word.exec_cmd = CMD_SUB; word.wb_en = 1'b1; end
            OP_AND:  begin word.exec_cmd = CMD_AND; word.wb_en = 1'b1; end
            OP_OR:   begin word.exec_cmd = CMD_OR;  word.wb_en = 1'b1; end
            OP_NOR:  begin word.exec_cmd = CMD_NOR; word.wb_en = 1'b1; end
            OP_XOR:  begin word.exec_cmd = CMD_XOR; word.wb_en = 1'b1; end
            OP_SLA,
            OP_SLL:  begin word.exec_cmd = CMD_SHL; word.wb_en = 1'b1; end
            OP_SRA:  begin word.exec_cmd = CMD_SRA; word.wb_en = 1'b1; end
            OP_SRL:  begin word.exec_cmd = CMD_SRL; word.wb_en = 1'b1; end
            OP_ADDI: begin
                word.exec_cmd = CMD_ADD; word.wb_en = 1'b1;
                word.is_imm = 1'b1; word.single_src = 1'b1;
            end
            OP_SUBI: begin
                word.exec_cmd = CMD_SUB; word.wb_en = 1'b1;
                word.is_imm = 1'b1; word.single_src = 1'b1;
            end
            OP_LD: begin
                word.exec_cmd = CMD_ADD; word.mem_r_en = 1'b1; word.wb_en = 1'b1;
                word.is_imm = 1'b1; word.single_src = 1'b1;
            end
            OP_ST: begin
                word.exec_cmd = CMD_ADD; word.mem_w_en = 1'b1; word.is_imm = 1'b1;
            end
            OP_BEZ: begin
                word.branch_type = BR_BEZ; word.is_imm = 1'b1; word.single_src = 1'b1;
            end
            OP_BNE: begin
                word.branch_type = BR_BNE; word.is_imm = 1'b1;
            end
            OP_JMP: begin
                word.branch_type = BR_JMP; word.is_imm = 1'b1; word.single_src = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/seq_control_unit.sv
// ID-stage control unit with a SWAP macro-op sequencer, stall/flush masking.
// Optional macro CTRL_ILLEGAL_TRAP_EN enables the sticky illegal_op flag.
module seq_control_unit
    import seq_control_unit_pkg::*;
#(
    parameter int               OPC_W         = OPC_WIDTH,
    parameter int               CMD_W         = CMD_WIDTH,
    parameter logic [OPC_W-1:0] SWAP_OPC      = 6'h3F,
    parameter int               SWAP_STEPS    = 2,
    parameter logic [CMD_W-1:0] SWAP_CMD_BASE = 4'b1100,
    parameter int               SEL_W         = 3
)(
    input  logic              clk,
    input  logic              rst,
    seq_control_unit_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(SWAP_STEPS - 1);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] step_reg, step_next;
    logic             is_swap;
    ctrl_word_t       dec_word;
    logic             dec_valid;

    seq_control_unit_decode u_decode (
        .opcode (bus.opcode),
        .word   (dec_word),
        .valid  (dec_valid)
    );

    // step_reg is 0 whenever the FSM is idle, so it is the current step in both states.
    assign is_swap = (state_reg == ST_SEQ) || (bus.opcode == SWAP_OPC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
            step_next  = '0;
        end else if (!bus.hazard_stall && is_swap) begin
            if (step_reg == LAST_STEP) begin
                state_next = ST_IDLE;
                step_next  = '0;
            end else begin
                state_next = ST_SEQ;
                step_next  = step_reg + SEL_W'(1);
            end
        end
    end

    always_comb begin
        bus.freeze      = 1'b0;
        bus.swp_sel     = '0;
        bus.exec_cmd    = '0;
        bus.mem_r_en    = 1'b0;
        bus.mem_w_en    = 1'b0;
        bus.wb_en       = 1'b0;
        bus.is_imm      = 1'b0;
        bus.single_src  = 1'b0;
        bus.branch_type = 2'b00;
        if (rst || bus.flush || bus.hazard_stall) begin
            // bubble: everything stays 0
        end else if (is_swap) begin
            bus.exec_cmd = SWAP_CMD_BASE + CMD_W'(step_reg);
            bus.swp_sel  = step_reg + SEL_W'(1);
            bus.wb_en    = 1'b1;
            bus.freeze   = (step_reg != LAST_STEP);
        end else begin
            bus.exec_cmd    = CMD_W'(dec_word.exec_cmd);
            bus.mem_r_en    = dec_word.mem_r_en;
            bus.mem_w_en    = dec_word.mem_w_en;
            bus.wb_en       = dec_word.wb_en;
            bus.is_imm      = dec_word.is_imm;
            bus.single_src  = dec_word.single_src;
            bus.branch_type = dec_word.branch_type;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && !bus.flush && !bus.hazard_stall
                     && !is_swap && !dec_valid) begin
            illegal_reg <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_reg;
`else
    logic unused_dec_valid;
    assign unused_dec_valid = dec_valid;
    assign bus.illegal_op   = 1'b0;
`endif

endmodule
